// File: rtl/qsfp_link_monitor_if.sv
// Status/LED bundle for one QSFP link monitor.
// The status source (block design) is the master; the monitor is the slave.
// state_dbg mirrors the monitor FSM state for observation and checkers.
interface qsfp_link_monitor_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) ();
    logic             channel_up_in;
    logic [LANES-1:0] lane_up_in;
    logic             gt_pll_lock_in;
    logic             ddr_calib_in;
    logic             clr_drop_count;
    logic             led_channel;
    logic             led_lanes;
    logic             led_pll;
    logic             led_ddr;
    logic             link_stable;
    logic             drop_event;
    logic [CNT_W-1:0] drop_count;
    logic [2:0]       state_dbg;

    modport master (
        output channel_up_in, lane_up_in, gt_pll_lock_in, ddr_calib_in, clr_drop_count,
        input  led_channel, led_lanes, led_pll, led_ddr, link_stable, drop_event,
               drop_count, state_dbg
    );

    modport slave (
        input  channel_up_in, lane_up_in, gt_pll_lock_in, ddr_calib_in, clr_drop_count,
        output led_channel, led_lanes, led_pll, led_ddr, link_stable, drop_event,
               drop_count, state_dbg
    );
endinterface

// File: rtl/qsfp_link_monitor.sv
// QSFP link monitor: synchronises raw Aurora/DDR status, qualifies channel_up
// with a debounce window, counts link drops (saturating) and drives status LEDs.
// led_channel: off = no PLL lock, slow blink = locked/qualifying,
// solid = link up, fast blink = recently dropped.
module qsfp_link_monitor #(
    parameter int LANES        = 4,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int DROP_STRETCH = 50_000_000,
    parameter int CNT_W        = 16
) (
    input logic                clk,
    input logic                rst,
    qsfp_link_monitor_if.slave bus
);
    // Fast blink is a quarter of the slow half period, never below one cycle.
    localparam int FAST_HALF = (BLINK_HALF / 4 > 0) ? BLINK_HALF / 4 : 1;
    localparam int QUAL_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int STR_W     = $clog2(DROP_STRETCH + 1);
    localparam int SLOW_W    = $clog2(BLINK_HALF + 1);
    localparam int FAST_W    = $clog2(FAST_HALF + 1);

    localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(DEBOUNCE_CYC - 1);
    localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(DROP_STRETCH - 1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(BLINK_HALF - 1);
    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);

    typedef enum logic [2:0] {
        ST_NOLOCK  = 3'd0,
        ST_LOCKED  = 3'd1,
        ST_QUALIFY = 3'd2,
        ST_UP      = 3'd3,
        ST_DROPPED = 3'd4
    } state_t;

    state_t            state;
    logic [QUAL_W-1:0] qual_cnt;
    logic [STR_W-1:0]  stretch_cnt;
    logic [SLOW_W-1:0] slow_cnt;
    logic [FAST_W-1:0] fast_cnt;
    logic              slow_phase;
    logic              fast_phase;

    logic             ch_m, ch_s;
    logic             pll_m, pll_s;
    logic             ddr_m, ddr_s;
    logic [LANES-1:0] lane_m, lane_s;

    logic             link_stable_q;
    logic             drop_event_q;
    logic [CNT_W-1:0] drop_count_q;
    logic             led_channel_q;
    logic             led_lanes_q;
    logic             led_pll_q;
    logic             led_ddr_q;

    // Two-flop synchronisers for every asynchronous status input.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_m   <= 1'b0;
            ch_s   <= 1'b0;
            pll_m  <= 1'b0;
            pll_s  <= 1'b0;
            ddr_m  <= 1'b0;
            ddr_s  <= 1'b0;
            lane_m <= '0;
            lane_s <= '0;
        end else begin
            ch_m   <= bus.channel_up_in;
            ch_s   <= ch_m;
            pll_m  <= bus.gt_pll_lock_in;
            pll_s  <= pll_m;
            ddr_m  <= bus.ddr_calib_in;
            ddr_s  <= ddr_m;
            lane_m <= bus.lane_up_in;
            lane_s <= lane_m;
        end
    end

    // Free-running blink generators; both phases start low after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slow_cnt   <= '0;
            slow_phase <= 1'b0;
            fast_cnt   <= '0;
            fast_phase <= 1'b0;
        end else begin
            if (slow_cnt == SLOW_LAST) begin
                slow_cnt   <= '0;
                slow_phase <= ~slow_phase;
            end else begin
                slow_cnt <= slow_cnt + 1'b1;
            end
            if (fast_cnt == FAST_LAST) begin
                fast_cnt   <= '0;
                fast_phase <= ~fast_phase;
            end else begin
                fast_cnt <= fast_cnt + 1'b1;
            end
        end
    end

    // Link FSM with registered link_stable, drop_event and saturating drop_count.
    // A drop together with a clear leaves the count at one: the clear wipes
    // history, the new drop is still recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_NOLOCK;
            qual_cnt      <= '0;
            stretch_cnt   <= '0;
            link_stable_q <= 1'b0;
            drop_event_q  <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            drop_event_q <= 1'b0;
            if (bus.clr_drop_count) begin
                drop_count_q <= '0;
            end
            case (state)
                ST_NOLOCK: begin
                    if (pll_s) begin
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!pll_s) begin
                        state <= ST_NOLOCK;
                    end else if (ch_s) begin
                        state    <= ST_QUALIFY;
                        qual_cnt <= '0;
                    end
                end
                ST_QUALIFY: begin
                    if (!pll_s) begin
                        state <= ST_NOLOCK;
                    end else if (!ch_s) begin
                        state <= ST_LOCKED;
                    end else if (qual_cnt == QUAL_LAST) begin
                        state         <= ST_UP;
                        link_stable_q <= 1'b1;
                    end else begin
                        qual_cnt <= qual_cnt + 1'b1;
                    end
                end
                ST_UP: begin
                    if (!ch_s || !pll_s) begin
                        state         <= ST_DROPPED;
                        link_stable_q <= 1'b0;
                        drop_event_q  <= 1'b1;
                        stretch_cnt   <= '0;
                        if (bus.clr_drop_count) begin
                            drop_count_q <= CNT_W'(1);
                        end else if (drop_count_q != {CNT_W{1'b1}}) begin
                            drop_count_q <= drop_count_q + 1'b1;
                        end
                    end
                end
                ST_DROPPED: begin
                    // Inputs are ignored while the drop indication is stretched.
                    if (stretch_cnt == STR_LAST) begin
                        state <= pll_s ? ST_LOCKED : ST_NOLOCK;
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_NOLOCK;
                end
            endcase
        end
    end

    // Registered LED drive; channel LED pattern follows the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_channel_q <= 1'b0;
            led_lanes_q   <= 1'b0;
            led_pll_q     <= 1'b0;
            led_ddr_q     <= 1'b0;
        end else begin
            case (state)
                ST_NOLOCK:             led_channel_q <= 1'b0;
                ST_LOCKED, ST_QUALIFY: led_channel_q <= slow_phase;
                ST_UP:                 led_channel_q <= 1'b1;
                ST_DROPPED:            led_channel_q <= fast_phase;
                default:               led_channel_q <= 1'b0;
            endcase
            led_lanes_q <= &lane_s;
            led_pll_q   <= pll_s;
            led_ddr_q   <= ddr_s;
        end
    end

    assign bus.led_channel = led_channel_q;
    assign bus.led_lanes   = led_lanes_q;
    assign bus.led_pll     = led_pll_q;
    assign bus.led_ddr     = led_ddr_q;
    assign bus.link_stable = link_stable_q;
    assign bus.drop_event  = drop_event_q;
    assign bus.drop_count  = drop_count_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_qsfp_link_monitor.sv
// Testbench for qsfp_link_monitor with small parameters: directed scenarios,
// an event/timestamp-based reference model compared every cycle, and literal
// expectations at hand-computed cycles.
module tb_qsfp_link_monitor;
    localparam int LANES        = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int BLINK_HALF   = 4;
    localparam int DROP_STRETCH = 16;
    localparam int CNT_W        = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // Model modes (independent labels, not the DUT encoding).
    localparam int M_NOLOCK  = 100;
    localparam int M_LOCKED  = 101;
    localparam int M_QUALIFY = 102;
    localparam int M_UP      = 103;
    localparam int M_DROPPED = 104;

    logic clk;
    logic rst;

    qsfp_link_monitor_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    qsfp_link_monitor #(
        .LANES        (LANES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .BLINK_HALF   (BLINK_HALF),
        .DROP_STRETCH (DROP_STRETCH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synced inputs are the raw inputs delayed two edges;
    // mode durations are measured as edge-count differences from entry time.
    int   n;
    int   m_mode;
    int   m_enter;
    int   m_next;
    int   m_drops;
    bit   model_ok = 1'b0;
    logic p_d1, p_d2, c_d1, c_d2, d_d1, d_d2;
    logic [LANES-1:0] l_d1, l_d2;
    logic e_led_channel, e_led_lanes, e_led_pll, e_led_ddr, e_link_stable, e_drop_event;
    logic [CNT_W-1:0] e_drop_count;

    function automatic logic slow_at(input int k);
        return ((k / BLINK_HALF) % 2) == 1;
    endfunction

    function automatic logic fast_at(input int k);
        return ((k / (BLINK_HALF / 4)) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_mode = M_NOLOCK; m_enter = 0; m_drops = 0;
            {p_d1, p_d2, c_d1, c_d2, d_d1, d_d2} = '0;
            l_d1 = '0; l_d2 = '0;
            {e_led_channel, e_led_lanes, e_led_pll, e_led_ddr, e_link_stable, e_drop_event} = '0;
            e_drop_count = '0;
            model_ok = 1'b1;
        end else begin
            // LEDs show what the link looked like just before this edge.
            if (m_mode == M_NOLOCK) e_led_channel = 1'b0;
            else if (m_mode == M_UP) e_led_channel = 1'b1;
            else if (m_mode == M_DROPPED) e_led_channel = fast_at(n);
            else e_led_channel = slow_at(n);
            e_led_lanes = &l_d2;
            e_led_pll   = p_d2;
            e_led_ddr   = d_d2;
            e_drop_event = 1'b0;
            if (bus.clr_drop_count) m_drops = 0;
            m_next = m_mode;
            if (m_mode == M_NOLOCK) begin
                if (p_d2) m_next = M_LOCKED;
            end else if (m_mode == M_DROPPED) begin
                if (n - m_enter == DROP_STRETCH) m_next = p_d2 ? M_LOCKED : M_NOLOCK;
            end else if (m_mode == M_UP) begin
                if (!p_d2 || !c_d2) begin
                    m_next = M_DROPPED;
                    e_drop_event = 1'b1;
                    m_drops++;
                end
            end else if (!p_d2) begin
                m_next = M_NOLOCK;
            end else if (m_mode == M_LOCKED) begin
                if (c_d2) m_next = M_QUALIFY;
            end else begin
                if (!c_d2) m_next = M_LOCKED;
                else if (n - m_enter == DEBOUNCE_CYC) m_next = M_UP;
            end
            if (m_next != m_mode) m_enter = n;
            m_mode = m_next;
            e_link_stable = (m_mode == M_UP);
            e_drop_count = CNT_W'((m_drops > CNT_MAX) ? CNT_MAX : m_drops);
            p_d2 = p_d1; p_d1 = bus.gt_pll_lock_in;
            c_d2 = c_d1; c_d1 = bus.channel_up_in;
            d_d2 = d_d1; d_d1 = bus.ddr_calib_in;
            l_d2 = l_d1; l_d1 = bus.lane_up_in;
            n++;
        end
    end

    // Scoreboard compare on every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (model_ok) begin
            check("led_channel", 32'(bus.led_channel), 32'(e_led_channel));
            check("led_lanes",   32'(bus.led_lanes),   32'(e_led_lanes));
            check("led_pll",     32'(bus.led_pll),     32'(e_led_pll));
            check("led_ddr",     32'(bus.led_ddr),     32'(e_led_ddr));
            check("link_stable", 32'(bus.link_stable), 32'(e_link_stable));
            check("drop_event",  32'(bus.drop_event),  32'(e_drop_event));
            check("drop_count",  32'(bus.drop_count),  32'(e_drop_count));
        end
    end

    // Driver tasks
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led_channel"}, 32'(bus.led_channel), 32'd0);
        check({tag, "_led_lanes"},   32'(bus.led_lanes),   32'd0);
        check({tag, "_led_pll"},     32'(bus.led_pll),     32'd0);
        check({tag, "_led_ddr"},     32'(bus.led_ddr),     32'd0);
        check({tag, "_link_stable"}, 32'(bus.link_stable), 32'd0);
        check({tag, "_drop_event"},  32'(bus.drop_event),  32'd0);
        check({tag, "_drop_count"},  32'(bus.drop_count),  32'd0);
    endtask

    // channel_up rises with PLL already locked: UP on the 11th edge.
    task automatic bring_up(input string tag);
        bus.channel_up_in = 1'b1;
        tick(10);
        check({tag, "_stable_e10"}, 32'(bus.link_stable), 32'd0);
        tick(1);
        check({tag, "_stable_e11"}, 32'(bus.link_stable), 32'd1);
        tick(1);
        check({tag, "_ledch_solid"}, 32'(bus.led_channel), 32'd1);
    endtask

    // One-cycle channel_up glitch while UP, then wait for re-qualification.
    task automatic drop_cycle();
        bus.channel_up_in = 1'b0;
        tick(1);
        bus.channel_up_in = 1'b1;
        tick(30);
    endtask

    int exp_counts[4] = '{1, 2, 3, 3};

    initial begin
        rst = 1'b1;
        bus.channel_up_in  = 1'b0;
        bus.lane_up_in     = '0;
        bus.gt_pll_lock_in = 1'b0;
        bus.ddr_calib_in   = 1'b0;
        bus.clr_drop_count = 1'b0;
        tick(3);
        check_all_zero("reset");

        // Scenario 1: lock, slow blink, bring-up timing, lane LED latency.
        rst = 1'b0;
        bus.gt_pll_lock_in = 1'b1;
        bus.ddr_calib_in   = 1'b1;
        bus.lane_up_in     = 4'hf;
        tick(5);
        check("s1_slow_hi", 32'(bus.led_channel), 32'd1);
        check("s1_led_pll", 32'(bus.led_pll), 32'd1);
        tick(4);
        check("s1_slow_lo", 32'(bus.led_channel), 32'd0);
        bring_up("s1");
        check("s1_count", 32'(bus.drop_count), 32'd0);
        bus.lane_up_in = 4'h7;
        tick(2);
        check("s1_lanes_held", 32'(bus.led_lanes), 32'd1);
        tick(1);
        check("s1_lanes_low", 32'(bus.led_lanes), 32'd0);
        bus.lane_up_in = 4'hf;
        bus.ddr_calib_in = 1'b0;
        tick(4);
        check("s1_ddr_low", 32'(bus.led_ddr), 32'd0);
        bus.ddr_calib_in = 1'b1;

        // Scenario 3: single-cycle drop while UP, stretch, re-qualify.
        bus.channel_up_in = 1'b0;
        tick(1);
        bus.channel_up_in = 1'b1;
        tick(1);
        check("s3_evt_before", 32'(bus.drop_event), 32'd0);
        tick(1);
        check("s3_evt", 32'(bus.drop_event), 32'd1);
        check("s3_count", 32'(bus.drop_count), 32'd1);
        check("s3_stable_off", 32'(bus.link_stable), 32'd0);
        tick(1);
        check("s3_evt_once", 32'(bus.drop_event), 32'd0);
        tick(23);
        check("s3_requal_e27", 32'(bus.link_stable), 32'd0);
        tick(1);
        check("s3_requal_e28", 32'(bus.link_stable), 32'd1);

        // Scenario 4: clear, then four drops saturating at 3.
        bus.clr_drop_count = 1'b1;
        tick(1);
        bus.clr_drop_count = 1'b0;
        check("s4_cleared", 32'(bus.drop_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drop_cycle();
            check($sformatf("s4_count%0d", i), 32'(bus.drop_count), 32'(exp_counts[i]));
            check($sformatf("s4_up%0d", i), 32'(bus.link_stable), 32'd1);
        end

        // Scenario 5: clear coincident with a drop while count is 2.
        bus.clr_drop_count = 1'b1;
        tick(1);
        bus.clr_drop_count = 1'b0;
        drop_cycle();
        drop_cycle();
        check("s5_pre", 32'(bus.drop_count), 32'd2);
        bus.channel_up_in = 1'b0;
        tick(1);
        bus.channel_up_in = 1'b1;
        tick(1);
        bus.clr_drop_count = 1'b1;
        tick(1);
        bus.clr_drop_count = 1'b0;
        check("s5_evt", 32'(bus.drop_event), 32'd1);
        check("s5_count", 32'(bus.drop_count), 32'd1);
        tick(28);

        // Scenario 2: abort qualification without counting a drop.
        bus.channel_up_in = 1'b0;
        tick(30);
        check("s2_locked", 32'(bus.link_stable), 32'd0);
        check("s2_count_pre", 32'(bus.drop_count), 32'd2);
        bus.channel_up_in = 1'b1;
        tick(5);
        bus.channel_up_in = 1'b0;
        tick(3);
        bring_up("s2");
        check("s2_count_post", 32'(bus.drop_count), 32'd2);

        // Scenario 6a: reset during QUALIFY.
        bus.channel_up_in = 1'b0;
        tick(30);
        bus.channel_up_in = 1'b1;
        tick(5);
        rst = 1'b1;
        bus.channel_up_in  = 1'b0;
        bus.gt_pll_lock_in = 1'b0;
        tick(1);
        check_all_zero("s6q");
        rst = 1'b0;
        bus.gt_pll_lock_in = 1'b1;
        tick(9);
        bring_up("s6q");
        check("s6q_count", 32'(bus.drop_count), 32'd0);

        // Scenario 6b: reset during DROPPED.
        bus.channel_up_in = 1'b0;
        tick(5);
        rst = 1'b1;
        bus.gt_pll_lock_in = 1'b0;
        tick(1);
        check_all_zero("s6d");
        rst = 1'b0;
        bus.gt_pll_lock_in = 1'b1;
        tick(9);
        bring_up("s6d");
        check("s6d_count", 32'(bus.drop_count), 32'd0);

        // PLL loss while UP also counts as a drop.
        bus.gt_pll_lock_in = 1'b0;
        tick(3);
        check("pll_drop_evt", 32'(bus.drop_event), 32'd1);
        tick(20);
        check("pll_nolock_led", 32'(bus.led_channel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
